// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences the shared datapath,
// stalls on the unified memory port and counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             IllegalInstr,
  output logic [CNT_W-1:0] RetireCount,
  output logic [3:0]       dbg_state
);

  // Memory handshake: the controller holds its request (address select,
  // MemWrite, IRWrite intent) stable every cycle until MemReady is sampled
  // high; the access completes on the rising edge where MemReady is 1.

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t           state, next_state;
  logic [1:0]       alu_op;
  logic             pc_update;
  logic             branch;
  logic             ir_write;
  logic             reg_write;
  logic             mem_write;
  logic             illegal;
  logic             retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      RetireCount <= '0;
    end else begin
      state <= next_state;
      if (retire) RetireCount <= RetireCount + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = MemReady;
        pc_update = MemReady;
        if (MemReady) next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default: begin
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (MemReady) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Enables are gated by reset_n so nothing writes while reset is held.
  assign PCWrite      = reset_n & (pc_update | (branch & Zero));
  assign IRWrite      = reset_n & ir_write;
  assign MemWrite     = reset_n & mem_write;
  assign RegWrite     = reset_n & reg_write;
  assign IllegalInstr = reset_n & illegal;
  assign dbg_state    = state;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sequences the shared datapath: register file, ALU, immediate extender, unified instruction/data memory port and PC/IR registers. Each cycle it decodes opcode/funct fields from the IR, then drives the extender's `ImmSrc`, the datapath mux selects, the write enables and `ALUControl`. It also stalls on memory and counts retired instructions.

## Interface
- `CNT_W`, 32: width of retired-instruction counter.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 7: `Instr[6:0]` from IR.
- `funct3` in 3: `Instr[14:12]`.
- `funct7b5` in 1: `Instr[30]`.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC load enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = Result.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: IR and OldPC load enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: Result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB` out 2: ALU B select. 00 = RD2, 01 = ImmExt, 10 = 4.
- `ImmSrc` out 2: extender format. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` out 3: ALU operation. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `IllegalInstr` out 1: one-cycle pulse in DECODE for an unsupported opcode.
- `RetireCount` out CNT_W: number of instructions retired.

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- `ImmSrc` is combinational from `op`: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Internal ALUOp decode:
  - 00 gives add.
  - 01 gives sub.
  - 10 decodes `funct3`: 000 gives sub if `op[5]&funct7b5`, else add; 010 slt; 110 or; 111 and; other add.
- `PCWrite = PCUpdate | (Branch & Zero)`.
- Unlisted mux selects are 00. Unlisted enables are 0.
- States and actions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate equal `MemReady`. Go to DECODE if `MemReady`, else hold.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
    - lw/sw go to MEMADR.
    - R-type goes to EXECUTER.
    - I-ALU goes to EXECUTEI.
    - beq goes to BEQ.
    - jal goes to JAL.
    - Anything else asserts IllegalInstr and goes to FETCH.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. `op[5]`=0 goes to MEMREAD, 1 goes to MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB on `MemReady`, else hold.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held until `MemReady`). Go to FETCH on `MemReady`.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- `RetireCount` increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W. The illegal-opcode path does not count.

## Timing
- The state register and `RetireCount` are the only flops. All other outputs are combinational from state and inputs (Moore, except the `MemReady` and `Zero` terms).
- Reset: `reset_n` low asynchronously forces state to FETCH and `RetireCount` to 0.
- While `reset_n` is low, PCWrite, IRWrite, MemWrite, RegWrite and IllegalInstr are forced to 0.
- First fetch happens on the first rising edge after release with `MemReady`=1.
- Cycle counts with `MemReady` tied high:
  - lw 5, sw 4.
  - R-type, I-ALU and jal 4.
  - beq 3.
  - Illegal opcode 2.
- Each cycle with `MemReady` low in FETCH, MEMREAD or MEMWRITE adds one cycle. During such a stall outputs stay constant and no write enable changes.
- Reset mid-instruction aborts it with no register or memory write, and the count is not incremented.

## Test plan
- Reset then add (op 0110011, funct3 000, funct7b5 0), `MemReady`=1 → states FETCH, DECODE, EXECUTER, ALUWB. ALUControl=000 in EXECUTER. RegWrite=1 only in ALUWB. RetireCount goes 0 to 1.
- sub (funct7b5 1) then addi with funct7b5 1 → ALUControl 001 for sub, 000 for addi. ImmSrc=00 for addi.
- lw with `MemReady` low 3 cycles in MEMREAD → lw takes 8 cycles total. AdrSrc=1 and RegWrite=0 throughout the stall. RegWrite=1 with ResultSrc=01 in MEMWB.
- beq with Zero=1, then beq with Zero=0 → PCWrite=1 in BEQ only for the first. ImmSrc=10. Both take 3 cycles and both increment RetireCount.
- jal → ImmSrc=11. PCWrite=1 in JAL, RegWrite=1 in ALUWB, ALUSrcA=01 and ALUSrcB=10 in JAL.
- Opcode 1111111, then `reset_n` pulsed low during a sw stall → IllegalInstr is high for one cycle and RetireCount does not change. On reset, MemWrite drops immediately, state is FETCH and RetireCount is 0.
